// File: rtl/btb_plru_nway.sv
// Tree pseudo-LRU replacement state, one (WAYS-1)-bit tree per set, with
// same-cycle read-touch, fill-touch and invalidate updates and a victim selector.
module btb_plru_nway #(
  parameter  int S_INDEX = 3,
  parameter  int WAYS    = 4,
  localparam int W_WAY   = $clog2(WAYS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               rd_touch,
  input  logic [S_INDEX-1:0] rd_index,
  input  logic [W_WAY-1:0]   rd_way,
  input  logic               wr_touch,
  input  logic [S_INDEX-1:0] wr_index,
  input  logic [W_WAY-1:0]   wr_way,
  input  logic               inv,
  input  logic [S_INDEX-1:0] inv_index,
  input  logic [W_WAY-1:0]   inv_way,
  input  logic [S_INDEX-1:0] vic_index,
  input  logic [WAYS-1:0]    valid_vec,
  output logic [W_WAY-1:0]   victim,
  output logic               victim_is_invalid
);

  localparam int NSETS = 2 ** S_INDEX;

  // Writes the path of `way` from the root down. A touch stores each level's
  // direction bit; an invalidate stores its inverse so the walk lands on `way`.
  function automatic logic [WAYS-2:0] path_write(
    input logic [WAYS-2:0] tree,
    input logic [W_WAY-1:0] way,
    input logic             invert
  );
    logic [WAYS-2:0]  t;
    logic [W_WAY-1:0] node;
    logic [W_WAY-1:0] w;
    logic             dir;
    t    = tree;
    node = '0;
    w    = way;
    for (int l = 0; l < W_WAY; l++) begin
      dir     = w[W_WAY-1];
      t[node] = dir ^ invert;
      node    = dir ? W_WAY'(2 * 32'(node) + 2) : W_WAY'(2 * 32'(node) + 1);
      w       = w << 1;
    end
    return t;
  endfunction

  logic [NSETS-1:0][WAYS-2:0] w_tree;

  for (genvar g = 0; g < NSETS; g++) begin : g_set
    logic [WAYS-2:0] r_tree;
    logic [WAYS-2:0] w_tree_nxt;

    // NOTE: blocking assignments chain the three updates so a later one
    // overwrites an earlier one only at the nodes their paths share.
    always_comb begin
      w_tree_nxt = r_tree;
      if (rd_touch && rd_index == S_INDEX'(g))
        w_tree_nxt = path_write(w_tree_nxt, rd_way, 1'b0);
      if (wr_touch && wr_index == S_INDEX'(g))
        w_tree_nxt = path_write(w_tree_nxt, wr_way, 1'b0);
      if (inv && inv_index == S_INDEX'(g))
        w_tree_nxt = path_write(w_tree_nxt, inv_way, 1'b1);
    end

    // NOTE: this storage is plain flops, not a RAM, so every set is cleared
    // directly by reset and flush.
    always_ff @(posedge clk) begin
      if (rst)        r_tree <= '0;
      else if (flush) r_tree <= '0;
      else            r_tree <= w_tree_nxt;
    end

    assign w_tree[g] = r_tree;
  end

  logic [WAYS-2:0]  w_sel_tree;
  logic [W_WAY-1:0] w_walk_node;
  logic [W_WAY-1:0] w_walk_vic;
  logic             w_walk_bit;
  logic [WAYS-1:0]  w_invalid;
  logic [W_WAY-1:0] w_low_cnt;
  logic [W_WAY-1:0] w_low_invalid;
  logic             w_found;

  // A node bit of 0 sends the walk right, 1 sends it left.
  always_comb begin
    w_sel_tree  = w_tree[vic_index];
    w_walk_node = '0;
    w_walk_vic  = '0;
    w_walk_bit  = 1'b0;
    for (int l = 0; l < W_WAY; l++) begin
      w_walk_bit  = ~w_sel_tree[w_walk_node];
      w_walk_vic  = W_WAY'({w_walk_vic, w_walk_bit});
      w_walk_node = w_walk_bit ? W_WAY'(2 * 32'(w_walk_node) + 2)
                               : W_WAY'(2 * 32'(w_walk_node) + 1);
    end
  end

  always_comb begin
    w_invalid     = ~valid_vec;
    w_low_cnt     = '0;
    w_low_invalid = '0;
    w_found       = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!w_found && w_invalid[0]) begin
        w_found       = 1'b1;
        w_low_invalid = w_low_cnt;
      end
      w_invalid = w_invalid >> 1;
      w_low_cnt = w_low_cnt + W_WAY'(1);
    end
  end

  assign victim_is_invalid = w_found;
  assign victim            = w_found ? w_low_invalid : w_walk_vic;

endmodule

// File: tb/tb_btb_plru_nway.sv
// Directed and model-driven checks of btb_plru_nway (4-way/8-set and 8-way/4-set
// instances); expected victims go through a scoreboard queue.
module tb_btb_plru_nway;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, flush;
  logic       rd_touch, wr_touch, inv;
  logic [2:0] rd_index, wr_index, inv_index, vic_index;
  logic [1:0] rd_way, wr_way, inv_way;
  logic [3:0] valid_vec;
  logic [1:0] victim;
  logic       victim_is_invalid;

  logic       b_rd_touch, b_wr_touch, b_inv;
  logic [1:0] b_rd_index, b_wr_index, b_inv_index, b_vic_index;
  logic [2:0] b_rd_way, b_wr_way, b_inv_way;
  logic [7:0] b_valid_vec;
  logic [2:0] b_victim;
  logic       b_victim_is_invalid;

  btb_plru_nway #(.S_INDEX(3), .WAYS(4)) u_dut_a (
    .clk(clk), .rst(rst), .flush(flush),
    .rd_touch(rd_touch), .rd_index(rd_index), .rd_way(rd_way),
    .wr_touch(wr_touch), .wr_index(wr_index), .wr_way(wr_way),
    .inv(inv), .inv_index(inv_index), .inv_way(inv_way),
    .vic_index(vic_index), .valid_vec(valid_vec),
    .victim(victim), .victim_is_invalid(victim_is_invalid)
  );

  btb_plru_nway #(.S_INDEX(2), .WAYS(8)) u_dut_b (
    .clk(clk), .rst(rst), .flush(flush),
    .rd_touch(b_rd_touch), .rd_index(b_rd_index), .rd_way(b_rd_way),
    .wr_touch(b_wr_touch), .wr_index(b_wr_index), .wr_way(b_wr_way),
    .inv(b_inv), .inv_index(b_inv_index), .inv_way(b_inv_way),
    .vic_index(b_vic_index), .valid_vec(b_valid_vec),
    .victim(b_victim), .victim_is_invalid(b_victim_is_invalid)
  );

  typedef struct {
    logic [2:0] vic;
    logic       inv;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Independent 4-way model: bit0 = root, bit1 = left child, bit2 = right child.
  logic [2:0] m_tree [8];

  function automatic logic [2:0] m_apply(input logic [2:0] t, input logic [1:0] w,
                                         input logic invert);
    logic [2:0] r;
    r    = t;
    r[0] = w[1] ^ invert;
    if (w[1]) r[2] = w[0] ^ invert;
    else      r[1] = w[0] ^ invert;
    return r;
  endfunction

  function automatic logic [2:0] m_victim(input logic [2:0] t, input logic [3:0] vv);
    for (int w = 0; w < 4; w++)
      if (!vv[w]) return {w[1:0], 1'b1};
    if (t[0]) return {1'b0, ~t[1], 1'b0};
    return {1'b1, ~t[2], 1'b0};
  endfunction

  task automatic m_step();
    logic [2:0] t;
    for (int s = 0; s < 8; s++) begin
      t = m_tree[s];
      if (rd_touch && rd_index == 3'(s)) t = m_apply(t, rd_way, 1'b0);
      if (wr_touch && wr_index == 3'(s)) t = m_apply(t, wr_way, 1'b0);
      if (inv && inv_index == 3'(s))     t = m_apply(t, inv_way, 1'b1);
      m_tree[s] = (rst || flush) ? 3'b000 : t;
    end
  endtask

  task automatic push(input logic [2:0] v, input logic i, input string tag);
    exp_t e;
    e.vic = v;
    e.inv = i;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic score(input logic [2:0] obs_v, input logic obs_i);
    exp_t e;
    n_vec++;
    if (sb.size() == 0) begin
      n_err++;
      $error("FAIL sb_empty: output seen with no expectation queued");
      return;
    end
    e = sb.pop_front();
    assert ({obs_v, obs_i} === {e.vic, e.inv}) else begin
      n_err++;
      $error("FAIL %s: victim=%0d invalid=%0b, expected victim=%0d invalid=%0b",
             e.tag, obs_v, obs_i, e.vic, e.inv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look_a(input logic [2:0] idx, input logic [3:0] vv,
                        input logic [1:0] ev, input logic ei, input string tag);
    vic_index = idx;
    valid_vec = vv;
    push({1'b0, ev}, ei, tag);
    @(negedge clk);
    score({1'b0, victim}, victim_is_invalid);
  endtask

  task automatic look_b(input logic [1:0] idx, input logic [7:0] vv,
                        input logic [2:0] ev, input logic ei, input string tag);
    b_vic_index = idx;
    b_valid_vec = vv;
    push(ev, ei, tag);
    @(negedge clk);
    score(b_victim, b_victim_is_invalid);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0;
    rd_touch = 1'b0; wr_touch = 1'b0; inv = 1'b0;
    rd_index = '0; wr_index = '0; inv_index = '0; vic_index = '0;
    rd_way = '0; wr_way = '0; inv_way = '0; valid_vec = 4'hF;
    b_rd_touch = 1'b0; b_wr_touch = 1'b0; b_inv = 1'b0;
    b_rd_index = '0; b_wr_index = '0; b_inv_index = '0; b_vic_index = '0;
    b_rd_way = '0; b_wr_way = '0; b_inv_way = '0; b_valid_vec = 8'hFF;
    tick();
    // Reset must override a touch in the same cycle.
    rd_touch = 1'b1; rd_index = 3'd2; rd_way = 2'd0;
    tick();
    rd_touch = 1'b0; rst = 1'b0;
    for (int i = 0; i < 8; i++) look_a(3'(i), 4'hF, 2'd3, 1'b0, "reset_state");

    rd_touch = 1'b1; rd_index = 3'd2; rd_way = 2'd3;
    tick();
    rd_touch = 1'b0;
    look_a(3'd2, 4'hF, 2'd1, 1'b0, "rd_touch_set2");
    look_a(3'd3, 4'hF, 2'd3, 1'b0, "set3_untouched");

    for (int w = 0; w < 4; w++) begin
      wr_touch = 1'b1; wr_index = 3'd5; wr_way = 2'(w);
      tick();
    end
    wr_touch = 1'b0;
    look_a(3'd5, 4'hF, 2'd0, 1'b0, "wr_seq_set5");
    rd_touch = 1'b1; rd_index = 3'd5; rd_way = 2'd0;
    tick();
    rd_touch = 1'b0;
    look_a(3'd5, 4'hF, 2'd2, 1'b0, "rd_way0_set5");

    do_reset();
    rd_touch = 1'b1; rd_index = 3'd4; rd_way = 2'd0;
    wr_touch = 1'b1; wr_index = 3'd4; wr_way = 2'd3;
    tick();
    rd_touch = 1'b0; wr_touch = 1'b0;
    look_a(3'd4, 4'hF, 2'd1, 1'b0, "rd_wr_same_set");
    rd_touch = 1'b1; rd_index = 3'd4; rd_way = 2'd0;
    wr_touch = 1'b1; wr_index = 3'd6; wr_way = 2'd3;
    tick();
    rd_touch = 1'b0; wr_touch = 1'b0;
    look_a(3'd4, 4'hF, 2'd2, 1'b0, "rd_wr_split_s4");
    look_a(3'd6, 4'hF, 2'd1, 1'b0, "rd_wr_split_s6");

    do_reset();
    inv = 1'b1; inv_index = 3'd1; inv_way = 2'd2;
    tick();
    inv = 1'b0;
    look_a(3'd1, 4'hF, 2'd2, 1'b0, "inv_way2_set1");
    look_a(3'd0, 4'b1011, 2'd2, 1'b1, "invalid_way2");
    look_a(3'd0, 4'b0000, 2'd0, 1'b1, "all_invalid");
    look_a(3'd1, 4'b0111, 2'd3, 1'b1, "invalid_way3");
    rd_touch = 1'b1; rd_index = 3'd7; rd_way = 2'd2;
    inv = 1'b1; inv_index = 3'd7; inv_way = 2'd2;
    tick();
    rd_touch = 1'b0; inv = 1'b0;
    look_a(3'd7, 4'hF, 2'd2, 1'b0, "inv_after_touch");

    tick();
    rd_touch = 1'b1; rd_index = 3'd0; rd_way = 2'd3;
    look_a(3'd0, 4'hF, 2'd3, 1'b0, "no_bypass");
    tick();
    rd_touch = 1'b0;
    look_a(3'd0, 4'hF, 2'd1, 1'b0, "touch_visible");

    rd_touch = 1'b1; rd_index = 3'd2; rd_way = 2'd0;
    wr_touch = 1'b1; wr_index = 3'd3; wr_way = 2'd1;
    tick();
    rd_touch = 1'b0;
    flush = 1'b1; wr_touch = 1'b1; wr_index = 3'd5; wr_way = 2'd0;
    tick();
    flush = 1'b0; wr_touch = 1'b0;
    for (int i = 0; i < 8; i++) look_a(3'(i), 4'hF, 2'd3, 1'b0, "flush");

    do_reset();
    look_b(2'd0, 8'hFF, 3'd7, 1'b0, "b_reset");
    for (int w = 0; w < 8; w++) begin
      b_wr_touch = 1'b1; b_wr_index = 2'd1; b_wr_way = 3'(w);
      tick();
    end
    b_wr_touch = 1'b0;
    look_b(2'd1, 8'hFF, 3'd0, 1'b0, "b_seq_touch");
    look_b(2'd0, 8'hFF, 3'd7, 1'b0, "b_other_set");
    look_b(2'd1, 8'hEF, 3'd4, 1'b1, "b_invalid_way4");
    do_reset();
    look_b(2'd1, 8'hFF, 3'd7, 1'b0, "b_reset_again");

    // Random traffic against the independent model.
    do_reset();
    for (int s = 0; s < 8; s++) m_tree[s] = 3'b000;
    for (int c = 0; c < 400; c++) begin
      rst       = ($urandom_range(0, 63) == 0);
      flush     = ($urandom_range(0, 31) == 0);
      rd_touch  = 1'($urandom_range(0, 1));
      wr_touch  = 1'($urandom_range(0, 1));
      inv       = ($urandom_range(0, 3) == 0);
      rd_index  = 3'($urandom_range(0, 3));
      wr_index  = 3'($urandom_range(0, 3));
      inv_index = 3'($urandom_range(0, 3));
      rd_way    = 2'($urandom_range(0, 3));
      wr_way    = 2'($urandom_range(0, 3));
      inv_way   = 2'($urandom_range(0, 3));
      vic_index = 3'($urandom_range(0, 3));
      valid_vec = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      push({1'b0, m_victim(m_tree[vic_index], valid_vec)}, 1'b0, "");
      sb[sb.size()-1].vic = {1'b0, sb[sb.size()-1].vic[2:1]};
      sb[sb.size()-1].inv = m_victim(m_tree[vic_index], valid_vec) & 3'b001 ? 1'b1 : 1'b0;
      sb[sb.size()-1].tag = $sformatf("random_c%0d_set%0d", c, vic_index);
      @(negedge clk);
      score({1'b0, victim}, victim_is_invalid);
      @(posedge clk);
      m_step();
      #1;
    end
    rst = 1'b0; flush = 1'b0; rd_touch = 1'b0; wr_touch = 1'b0; inv = 1'b0;

    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL sb_leftover: %0d expectations never compared, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/btb_plru_nway.md
Name: btb_plru_nway

Overview:
- Parametrised tree pseudo-LRU replacement state for the set-associative BTB, and for any other set-associative structure in the core.
- Holds one (WAYS-1)-bit tree per set and applies up to three updates per cycle: read-hit touch, fill touch and invalidate.
- Produces a victim way every cycle, preferring invalid ways, for the fill path of the owning array.

Parameters:
- S_INDEX, 3, set index width; NSETS = 2**S_INDEX.
- WAYS, 4, associativity; power of two, >= 2.
- W_WAY, $clog2(WAYS), way field width; derived, never overridden.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- flush  in  1  clear every tree to reset value.
- rd_touch  in  1  read hit; mark rd_way MRU in set rd_index.
- rd_index  in  S_INDEX  read set.
- rd_way  in  W_WAY  way hit on read.
- wr_touch  in  1  fill/write; mark wr_way MRU in set wr_index.
- wr_index  in  S_INDEX  write set.
- wr_way  in  W_WAY  way written.
- inv  in  1  invalidate; make inv_way LRU in set inv_index.
- inv_index  in  S_INDEX  invalidate set.
- inv_way  in  W_WAY  way invalidated.
- vic_index  in  S_INDEX  set whose victim is requested.
- valid_vec  in  WAYS  per-way valid bits of set vic_index.
- victim  out  W_WAY  way to replace.
- victim_is_invalid  out  1  victim chosen from an invalid way.

Behaviour:
- Reset is synchronous and active-high: rst sampled on posedge clk clears all trees to 0. It overrides flush and all updates in the same cycle.
- Tree encoding: node n (0-based heap) has children 2n+1 and 2n+2. Leaves run left to right as ways 0..WAYS-1. The way MSB selects the branch at the root.
- Node bit records the most recent access direction: 0 = left, 1 = right.
- Touch (rd or wr): every node on the way's path is written with that way's direction bit at the node. Nodes off the path are unchanged.
- Invalidate: every node on the path is written with the inverted direction bit. This points the victim walk at inv_way.
- Victim walk from the root: bit 0 goes right, bit 1 goes left, through W_WAY levels.
- With all bits 0 the victim is way WAYS-1.
- Same-cycle updates are applied in order rd_touch, then wr_touch, then inv, per node. Where paths overlap in the same set, the later update wins at each shared node. Different sets update independently.
- flush (without rst): every tree is 0 next cycle. All touches and invalidates in that cycle are discarded.
- Outputs are combinational from registered state and valid_vec, and are valid every cycle (not gated by any strobe).
- Same-cycle updates to vic_index are not bypassed; they are visible from the next cycle.
- If any valid_vec bit is 0: victim = lowest-numbered invalid way and victim_is_invalid = 1. Otherwise victim comes from the tree walk and victim_is_invalid = 0.
- Output values after reset with valid_vec all ones: victim = WAYS-1, victim_is_invalid = 0.
- Indices and ways are always in range by construction; no X handling is required beyond reset.
- Storage is a flop array, NSETS x (WAYS-1) bits. There is no RAM macro.

Test Plan:
- Reset, valid_vec=4'hF, vic_index=0..7 -> victim=3, victim_is_invalid=0 for every set.
- rd_touch way 3 on set 2, then vic_index=2 -> victim=1. Set 3 is unaffected (victim=3).
- wr_touch ways 0,1,2,3 on set 5 in consecutive cycles -> victim=0. Then rd_touch way 0 -> victim=2.
- After reset, same cycle: rd_touch way 0 and wr_touch way 3, both set 4 -> tree root=1, node1=0, node2=1, giving victim=1. Repeat with different indices 4 and 6 -> set 4 victim=2, set 6 victim=1.
- After reset, inv way 2 on set 1 -> victim=2. Then valid_vec=4'b1011 on set 0 -> victim=2, victim_is_invalid=1. valid_vec=4'b0000 -> victim=0, victim_is_invalid=1.
- Touch several sets, then flush asserted together with wr_touch set 5 way 0 -> next cycle all sets victim=3. Rerun with WAYS=8, S_INDEX=2: touching ways 0..7 in order gives victim=0; reset gives victim=7.
